// File: rtl/div_sequencer.sv
// Control stage in front of the 8-bit serial restoring divider.
// Sequences operands in, start pulse out, and results downstream.
module div_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_num,
    input  logic [7:0] in_den,
    output logic [7:0] div_numerator,
    output logic [7:0] div_denominator,
    output logic       div_start,
    input  logic [7:0] div_quotient,
    input  logic [7:0] div_remainder,
    input  logic       div_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_quotient,
    output logic [7:0] out_remainder,
    output logic       out_div_by_zero,
    output logic       out_error
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        DONE
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wd_q, wd_d;
    logic [7:0] num_q, num_d;
    logic [7:0] den_q, den_d;
    logic       start_q, start_d;
    logic       valid_q, valid_d;
    logic [7:0] quo_q, quo_d;
    logic [7:0] rem_q, rem_d;
    logic       dbz_q, dbz_d;
    logic       err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wd_q    <= 8'd0;
            num_q   <= 8'd0;
            den_q   <= 8'd0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            quo_q   <= 8'd0;
            rem_q   <= 8'd0;
            dbz_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            num_q   <= num_d;
            den_q   <= den_d;
            start_q <= start_d;
            valid_q <= valid_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        num_d   = num_q;
        den_d   = den_q;
        start_d = 1'b0;
        valid_d = valid_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_den != 8'd0) begin
                        num_d   = in_num;
                        den_d   = in_den;
                        start_d = 1'b1;
                        state_d = START;
                    end else begin
                        quo_d   = 8'hFF;
                        rem_d   = in_num;
                        dbz_d   = 1'b1;
                        err_d   = 1'b0;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            // div_ready may still be high from the previous op here
            START: begin
                wd_d    = 8'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (div_ready) begin
                    quo_d   = div_quotient;
                    rem_d   = div_remainder;
                    dbz_d   = 1'b0;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else if (wd_q == WD_LAST) begin
                    quo_d   = 8'd0;
                    rem_d   = 8'd0;
                    dbz_d   = 1'b0;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else if (wd_q != 8'hFF) begin
                    wd_d = wd_q + 8'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    dbz_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready        = (state_q == IDLE);
    assign div_numerator   = num_q;
    assign div_denominator = den_q;
    assign div_start       = start_q;
    assign out_valid       = valid_q;
    assign out_quotient    = quo_q;
    assign out_remainder   = rem_q;
    assign out_div_by_zero = dbz_q;
    assign out_error       = err_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural
// 8-cycle divider stand-in that can be forced to hang.
module tb_div_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_num;
    logic [7:0] in_den;
    logic [7:0] div_numerator;
    logic [7:0] div_denominator;
    logic       div_start;
    logic [7:0] div_quotient;
    logic [7:0] div_remainder;
    logic       div_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_quotient;
    logic [7:0] out_remainder;
    logic       out_div_by_zero;
    logic       out_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_sequencer #(.TIMEOUT(15)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_num          (in_num),
        .in_den          (in_den),
        .div_numerator   (div_numerator),
        .div_denominator (div_denominator),
        .div_start       (div_start),
        .div_quotient    (div_quotient),
        .div_remainder   (div_remainder),
        .div_ready       (div_ready),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_quotient    (out_quotient),
        .out_remainder   (out_remainder),
        .out_div_by_zero (out_div_by_zero),
        .out_error       (out_error)
    );

    // Divider stand-in: loads on start, ready 8 edges later
    logic [7:0] m_q = 8'd0;
    logic [7:0] m_r = 8'd0;
    logic [3:0] m_cnt = 4'd8;
    logic       m_rdy = 1'b0;
    logic       hang = 1'b0;

    always @(posedge clk) begin
        if (div_start) begin
            m_q   <= div_numerator / div_denominator;
            m_r   <= div_numerator % div_denominator;
            m_cnt <= 4'd0;
            m_rdy <= 1'b0;
        end else if (m_cnt < 4'd8) begin
            m_cnt <= m_cnt + 4'd1;
            m_rdy <= (m_cnt == 4'd7);
        end
    end

    assign div_quotient  = m_q;
    assign div_remainder = m_r;
    assign div_ready     = m_rdy & ~hang;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int lat, output int starts,
                              output int rdy_hi);
        lat = -1;
        starts = 0;
        rdy_hi = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (div_start) starts++;
            if (in_ready) rdy_hi++;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic accept(input logic [7:0] n, input logic [7:0] d);
        in_valid = 1'b1;
        in_num = n;
        in_den = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        in_num = 8'd0;
        in_den = 8'd0;
        out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready got %b want 1", in_ready);
        end
        checks++;
        if ({out_valid, div_start, out_div_by_zero, out_error} !== 4'b0) begin
            errors++;
            $display("FAIL rst_flags got %b%b%b%b want 0000",
                     out_valid, div_start, out_div_by_zero, out_error);
        end
        checks++;
        if ({out_quotient, out_remainder, div_numerator, div_denominator}
            !== 32'd0) begin
            errors++;
            $display("FAIL rst_data got %h %h %h %h want 0",
                     out_quotient, out_remainder,
                     div_numerator, div_denominator);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        accept(8'd9, 8'd3);
        checks++;
        if (div_start !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_start got %b want 1", div_start);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({div_start, in_ready, out_valid} !== 3'b010) begin
            errors++;
            $display("FAIL async_start_clear got %b%b%b want 010",
                     div_start, in_ready, out_valid);
        end
        tick();
        reset = 1'b1;
        tick();
        accept(8'd42, 8'd0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_valid got %b want 1", out_valid);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out_div_by_zero} !== 3'b010) begin
            errors++;
            $display("FAIL async_done_clear got %b%b%b want 010",
                     out_valid, in_ready, out_div_by_zero);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat, st, rh;
        out_ready = 1'b1;
        accept(8'd200, 8'd7);
        checks++;
        if ({div_start, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL basic_start got %b%b want 10", div_start, in_ready);
        end
        checks++;
        if ({div_numerator, div_denominator} !== {8'd200, 8'd7}) begin
            errors++;
            $display("FAIL basic_operands got %0d/%0d want 200/7",
                     div_numerator, div_denominator);
        end
        wait_valid(lat, st, rh);
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("FAIL basic_latency got %0d want 10", lat);
        end
        checks++;
        if (st !== 0) begin
            errors++;
            $display("FAIL basic_extra_starts got %0d want 0", st);
        end
        checks++;
        if ({out_quotient, out_remainder, out_div_by_zero, out_error}
            !== {8'd28, 8'd4, 2'b00}) begin
            errors++;
            $display("FAIL basic_result got %0d,%0d dz%b er%b want 28,4 dz0 er0",
                     out_quotient, out_remainder, out_div_by_zero, out_error);
        end
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL basic_handshake got %b%b want 01",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat, st, rh;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_num = 8'd255;
        in_den = 8'd1;
        tick();
        in_num = 8'd3;
        in_den = 8'd10;
        wait_valid(lat, st, rh);
        checks++;
        if ({out_quotient, out_remainder} !== {8'd255, 8'd0}
            || lat !== 10) begin
            errors++;
            $display("FAIL b2b_first got %0d,%0d lat %0d want 255,0 lat 10",
                     out_quotient, out_remainder, lat);
        end
        checks++;
        if (rh !== 0) begin
            errors++;
            $display("FAIL b2b_first_in_ready got %0d high cycles want 0", rh);
        end
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_idle got %b%b want 01", out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({div_start, div_numerator, div_denominator}
            !== {1'b1, 8'd3, 8'd10}) begin
            errors++;
            $display("FAIL b2b_second_start got %b %0d/%0d want 1 3/10",
                     div_start, div_numerator, div_denominator);
        end
        wait_valid(lat, st, rh);
        checks++;
        if ({out_quotient, out_remainder} !== {8'd0, 8'd3}
            || lat !== 10 || rh !== 0) begin
            errors++;
            $display("FAIL b2b_second got %0d,%0d lat %0d rdy %0d want 0,3 lat 10 rdy 0",
                     out_quotient, out_remainder, lat, rh);
        end
        tick();
    endtask

    task automatic test_div_by_zero();
        out_ready = 1'b1;
        accept(8'd42, 8'd0);
        checks++;
        if ({out_valid, div_start} !== 2'b10) begin
            errors++;
            $display("FAIL dbz_valid got %b start %b want 1 start 0",
                     out_valid, div_start);
        end
        checks++;
        if ({out_quotient, out_remainder, out_div_by_zero, out_error}
            !== {8'd255, 8'd42, 2'b10}) begin
            errors++;
            $display("FAIL dbz_result got %0d,%0d dz%b er%b want 255,42 dz1 er0",
                     out_quotient, out_remainder, out_div_by_zero, out_error);
        end
        tick();
        checks++;
        if ({out_valid, out_div_by_zero, div_start, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL dbz_clear got %b%b%b%b want 0001",
                     out_valid, out_div_by_zero, div_start, in_ready);
        end
    endtask

    task automatic test_timeout();
        int lat, st, rh;
        out_ready = 1'b0;
        hang = 1'b1;
        accept(8'd10, 8'd2);
        wait_valid(lat, st, rh);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL timeout_latency got %0d want 16", lat);
        end
        checks++;
        if ({out_quotient, out_remainder, out_div_by_zero, out_error}
            !== {8'd0, 8'd0, 2'b01}) begin
            errors++;
            $display("FAIL timeout_result got %0d,%0d dz%b er%b want 0,0 dz0 er1",
                     out_quotient, out_remainder, out_div_by_zero, out_error);
        end
        out_ready = 1'b1;
        tick();
        hang = 1'b0;
        checks++;
        if ({out_valid, out_error, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL timeout_clear got %b%b%b want 001",
                     out_valid, out_error, in_ready);
        end
    endtask

    task automatic test_hold();
        int lat, st, rh;
        out_ready = 1'b0;
        accept(8'd100, 8'd9);
        wait_valid(lat, st, rh);
        checks++;
        if ({out_quotient, out_remainder} !== {8'd11, 8'd1} || lat !== 10) begin
            errors++;
            $display("FAIL hold_result got %0d,%0d lat %0d want 11,1 lat 10",
                     out_quotient, out_remainder, lat);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({out_valid, in_ready, out_quotient, out_remainder}
                !== {2'b10, 8'd11, 8'd1}) begin
                errors++;
                $display("FAIL hold_stall%0d got v%b r%b %0d,%0d want v1 r0 11,1",
                         i, out_valid, in_ready, out_quotient, out_remainder);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL hold_release got %b%b want 01", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_in_wait();
        int lat, st, rh;
        int seen;
        out_ready = 1'b1;
        accept(8'd60, 8'd6);
        tick();
        tick();
        tick();
        #2 reset = 1'b0;
        tick();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL wait_reset_valid got %0d valid cycles want 0", seen);
        end
        accept(8'd50, 8'd5);
        wait_valid(lat, st, rh);
        checks++;
        if ({out_quotient, out_remainder, out_error} !== {8'd10, 8'd0, 1'b0}
            || lat !== 10) begin
            errors++;
            $display("FAIL wait_reset_next got %0d,%0d er%b lat %0d want 10,0 er0 lat 10",
                     out_quotient, out_remainder, out_error, lat);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_basic();
        test_back_to_back();
        test_div_by_zero();
        test_timeout();
        test_hold();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got hang want finish");
        $fatal(1, "simulation time limit");
    end

endmodule
